// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, execute-unit states and width constants.
package alu_pkg;

   localparam int unsigned DATA_WIDTH  = 32;
   localparam int unsigned SHAMT_WIDTH = 5;

   typedef enum logic [3:0] {
      OP_AND = 4'b0000,
      OP_OR  = 4'b0001,
      OP_ADD = 4'b0010,
      OP_JAL = 4'b0011,
      OP_SLL = 4'b0100,
      OP_SRL = 4'b0101,
      OP_XOR = 4'b0110,
      OP_SRA = 4'b0111,
      OP_BEQ = 4'b1000,
      OP_BNE = 4'b1001,
      OP_BLT = 4'b1010,
      OP_BGE = 4'b1011,
      OP_SLT = 4'b1100,
      OP_SUB = 4'b1111
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } exec_state_e;

   function automatic logic is_shift(input alu_op_e op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Bit-serial shifter: one position per step, counting down the remaining shift amount.
module alu_shift_unit
   import alu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = alu_pkg::DATA_WIDTH,
   parameter int unsigned SHAMT_WIDTH = alu_pkg::SHAMT_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_load,
   input  logic                   i_step,
   input  logic                   i_left,
   input  logic                   i_arith,
   input  logic [DATA_WIDTH-1:0]  i_a,
   input  logic [SHAMT_WIDTH-1:0] i_shamt,
   output logic [DATA_WIDTH-1:0]  o_shifted,
   output logic                   o_last
);

   logic [DATA_WIDTH-1:0]  r_acc;
   logic [SHAMT_WIDTH-1:0] r_cnt;
   logic                   r_left;
   logic                   r_fill;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc  <= '0;
         r_cnt  <= '0;
         r_left <= 1'b0;
         r_fill <= 1'b0;
      end else if (i_load) begin
         r_acc  <= i_a;
         r_cnt  <= i_shamt;
         r_left <= i_left;
         r_fill <= i_arith & i_a[DATA_WIDTH-1];
      end else if (i_step) begin
         r_acc <= o_shifted;
         r_cnt <= r_cnt - SHAMT_WIDTH'(1);
      end
   end

   always_comb begin
      if (r_left) o_shifted = {r_acc[DATA_WIDTH-2:0], 1'b0};
      else        o_shifted = {r_fill, r_acc[DATA_WIDTH-1:1]};
   end

   assign o_last = (r_cnt == SHAMT_WIDTH'(1));

endmodule

// File: rtl/alu_seq_exec.sv
// Multi-cycle execute stage: single-cycle logic/arith/compare ops, bit-serial shifts,
// valid/ready handshakes on both sides.
module alu_seq_exec
   import alu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = alu_pkg::DATA_WIDTH,
   parameter int unsigned SHAMT_WIDTH = alu_pkg::SHAMT_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            operation,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  branch_taken
);

   localparam logic [DATA_WIDTH-1:0] JAL_INC = DATA_WIDTH'(4);

   exec_state_e             r_state, w_next;
   logic [DATA_WIDTH-1:0]   r_result, w_result, w_calc, w_shifted;
   logic                    r_taken, w_taken, w_calc_taken;
   logic                    w_res_we, w_load, w_step, w_last;
   logic [SHAMT_WIDTH-1:0]  w_shamt;
   alu_op_e                 w_op;

   assign w_op    = alu_op_e'(operation);
   assign w_shamt = b[SHAMT_WIDTH-1:0];

   // Shift codes yield the unshifted operand here; only used when shamt is zero.
   always_comb begin
      w_calc       = '0;
      w_calc_taken = 1'b0;
      case (w_op)
         OP_AND: w_calc = a & b;
         OP_OR:  w_calc = a | b;
         OP_XOR: w_calc = a ^ b;
         OP_ADD: w_calc = a + b;
         OP_SUB: w_calc = a - b;
         OP_JAL: begin
            w_calc       = a + JAL_INC;
            w_calc_taken = 1'b1;
         end
         OP_SLL, OP_SRL, OP_SRA: w_calc = a;
         OP_SLT: w_calc = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_BEQ: w_calc_taken = (a == b);
         OP_BNE: w_calc_taken = (a != b);
         OP_BLT: w_calc_taken = ($signed(a) <  $signed(b));
         OP_BGE: w_calc_taken = ($signed(a) >= $signed(b));
         default: ;
      endcase
   end

   always_comb begin
      w_next   = r_state;
      w_load   = 1'b0;
      w_step   = 1'b0;
      w_res_we = 1'b0;
      w_result = w_calc;
      w_taken  = w_calc_taken;
      case (r_state)
         ST_IDLE: begin
            if (in_valid) begin
               if (is_shift(w_op) && (w_shamt != '0)) begin
                  w_load = 1'b1;
                  w_next = ST_SHIFT;
               end else begin
                  w_res_we = 1'b1;
                  w_next   = ST_DONE;
               end
            end
         end
         ST_SHIFT: begin
            w_step = 1'b1;
            if (w_last) begin
               w_res_we = 1'b1;
               w_result = w_shifted;
               w_taken  = 1'b0;
               w_next   = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
      if (flush) begin
         w_next   = ST_IDLE;
         w_load   = 1'b0;
         w_step   = 1'b0;
         w_res_we = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_result <= '0;
         r_taken  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_res_we) begin
            r_result <= w_result;
            r_taken  <= w_taken;
         end
      end
   end

   alu_shift_unit #(
      .DATA_WIDTH  (DATA_WIDTH),
      .SHAMT_WIDTH (SHAMT_WIDTH)
   ) u_shift (
      .clk       (clk),
      .reset     (reset),
      .i_load    (w_load),
      .i_step    (w_step),
      .i_left    (w_op == OP_SLL),
      .i_arith   (w_op == OP_SRA),
      .i_a       (a),
      .i_shamt   (w_shamt),
      .o_shifted (w_shifted),
      .o_last    (w_last)
   );

   assign in_ready     = (r_state == ST_IDLE);
   assign out_valid    = (r_state == ST_DONE);
   assign result       = r_result;
   assign branch_taken = r_taken;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Randomized and directed checks of alu_seq_exec against an arithmetic reference model.
module tb_alu_seq_exec;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic        in_ready, out_valid, branch_taken;
   logic [3:0]  operation;
   logic [31:0] a, b, result;

   int total = 0;
   int bad   = 0;

   alu_seq_exec #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .operation    (operation),
      .a            (a),
      .b            (b),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .result       (result),
      .branch_taken (branch_taken)
   );

   always #5 clk = ~clk;

   function automatic void ref_model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] res, output logic tk, output int lat);
      int sh;
      sh  = int'(y % 32);
      res = 32'd0;
      tk  = 1'b0;
      lat = 1;
      case (op)
         4'd0:  res = x & y;
         4'd1:  res = x | y;
         4'd2:  res = 32'((64'(x) + 64'(y)) % 64'h1_0000_0000);
         4'd3:  begin res = 32'((64'(x) + 64'd4) % 64'h1_0000_0000); tk = 1'b1; end
         4'd4:  begin res = 32'((64'(x) * (64'd1 << sh)) % 64'h1_0000_0000); lat = 1 + sh; end
         4'd5:  begin res = x / (32'd1 << sh); lat = 1 + sh; end
         4'd6:  res = x ^ y;
         4'd7:  begin
                   res = 32'($signed(64'($signed(x))) >>> sh);
                   lat = 1 + sh;
                end
         4'd8:  tk = (x == y);
         4'd9:  tk = (x != y);
         4'd10: tk = ($signed(x) < $signed(y));
         4'd11: tk = !($signed(x) < $signed(y));
         4'd12: res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         4'd15: res = 32'((64'h1_0000_0000 + 64'(x) - 64'(y)) % 64'h1_0000_0000);
         default: ;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
   endtask

   task automatic run_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input int hold, input string name);
      logic [31:0] er;
      logic        et;
      int          el, lat;
      ref_model(op, av, bv, er, et, el);
      wait_ready();
      operation = op; a = av; b = bv; in_valid = 1'b1;
      lat = 0;
      do begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         lat++;
      end while (!out_valid && lat < 40);
      total++;
      if (lat !== el) begin
         bad++;
         $display("FAIL %s latency got=%0d exp=%0d", name, lat, el);
      end
      total++;
      if (result !== er) begin
         bad++;
         $display("FAIL %s result got=%h exp=%h", name, result, er);
      end
      total++;
      if (branch_taken !== et) begin
         bad++;
         $display("FAIL %s branch_taken got=%b exp=%b", name, branch_taken, et);
      end
      repeat (hold) begin
         @(posedge clk); #1;
         total++;
         if (out_valid !== 1'b1 || result !== er || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s hold out_valid=%b in_ready=%b result=%h exp=%h", name, out_valid, in_ready, result, er);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s handshake out_valid=%b in_ready=%b exp 0/1", name, out_valid, in_ready);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 || branch_taken !== 1'b0) begin
         bad++;
         $display("FAIL %s in_ready=%b out_valid=%b result=%h taken=%b exp 1/0/0/0",
                  name, in_ready, out_valid, result, branch_taken);
      end
   endtask

   task automatic test_reset();
      #1 check_reset_outputs("reset_initial");
      @(posedge clk); #1 reset = 1'b0;
      // reset while DONE holds a nonzero result
      operation = 4'd3; a = 32'h100; b = 32'd0; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      chk("reset_pre_done", {31'd0, out_valid}, 32'd1);
      #2 reset = 1'b1;
      #1 check_reset_outputs("reset_in_done");
      @(posedge clk); #1 reset = 1'b0;
      // reset mid-SHIFT
      operation = 4'd7; a = 32'h8000_0000; b = 32'd20; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3 reset = 1'b1;
      #1 check_reset_outputs("reset_in_shift");
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1 check_reset_outputs("reset_after_release");
   endtask

   task automatic test_directed();
      run_op(4'd2,  32'd5,          32'd7,          0, "add_5_7");
      run_op(4'd15, 32'd3,          32'd5,          0, "sub_3_5");
      run_op(4'd3,  32'h100,        32'd0,          0, "jal");
      run_op(4'd7,  32'h8000_0000,  32'd4,          0, "sra_4");
      run_op(4'd5,  32'h8000_0000,  32'd4,          0, "srl_4");
      run_op(4'd4,  32'h1234_5678,  32'h20,         0, "sll_shamt0");
      run_op(4'd4,  32'h0000_0001,  32'd31,         0, "sll_31");
      run_op(4'd7,  32'h8000_0001,  32'hFFFF_FFFF,  0, "sra_31");
      run_op(4'd8,  32'd7,          32'd7,          0, "beq_eq");
      run_op(4'd10, 32'hFFFF_FFFF,  32'd1,          0, "blt_neg");
      run_op(4'd11, 32'hFFFF_FFFF,  32'd1,          0, "bge_neg");
      run_op(4'd9,  32'd3,          32'd3,          0, "bne_eq");
      run_op(4'd12, 32'hFFFF_FFFE,  32'd1,          0, "slt_neg");
      run_op(4'd13, 32'hDEAD_BEEF,  32'h1234,       0, "undef_13");
      run_op(4'd14, 32'hDEAD_BEEF,  32'h1234,       0, "undef_14");
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         logic [31:0] ra, rb;
         logic [3:0]  rop;
         rop = 4'($urandom_range(0, 15));
         ra  = $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
         run_op(rop, ra, rb, int'($urandom_range(0, 2)), "random");
      end
   endtask

   task automatic test_backpressure();
      wait_ready();
      operation = 4'd2; a = 32'd100; b = 32'd23; in_valid = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         in_valid  = i[0];
         operation = 4'd0; a = $urandom; b = $urandom;
         @(posedge clk); #1;
         total++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd123) begin
            bad++;
            $display("FAIL backpressure out_valid=%b in_ready=%b result=%h exp 1/0/%h",
                     out_valid, in_ready, result, 32'd123);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL backpressure_release out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_flush();
      int seen_valid = 0;
      wait_ready();
      operation = 4'd4; a = 32'd1; b = 32'd31; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
         if (out_valid) seen_valid++;
      end
      flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || seen_valid != 0) begin
         bad++;
         $display("FAIL flush_shift in_ready=%b out_valid=%b early_valid=%0d exp 1/0/0",
                  in_ready, out_valid, seen_valid);
      end
      repeat (25) begin
         @(posedge clk); #1;
         if (out_valid) seen_valid++;
      end
      chk("flush_no_late_result", 32'(seen_valid), 32'd0);
      // flush beats a simultaneous in_valid in IDLE
      operation = 4'd2; a = 32'd1; b = 32'd1; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
      chk("flush_vs_accept", {31'd0, in_ready}, 32'd1);
      // flush beats a simultaneous out_ready in DONE
      operation = 4'd2; a = 32'd9; b = 32'd9; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      flush = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1 flush = 1'b0; out_ready = 1'b0;
      chk("flush_in_done", {30'd0, in_ready, out_valid}, 32'd2);
      run_op(4'd2, 32'd40, 32'd2, 0, "add_after_flush");
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      operation = 4'd0; a = 32'd0; b = 32'd0;
      test_reset();
      test_directed();
      test_backpressure();
      test_flush();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule

// File: doc/alu_seq_exec.md
# alu_seq_exec

Multi-cycle execute unit that consumes the 4-bit ALU operation code produced by the ALU control decoder and performs the selected operation on two operands. Logic, arithmetic and compare operations finish in one cycle; shifts iterate one bit position per cycle. Valid/ready handshakes on both sides let the execute stage stall the pipeline while a shift runs. The unit sits between operand select (SrcA/SrcB mux) and the memory/writeback stage.

## Interface
- DATA_WIDTH, 32, operand/result width
- SHAMT_WIDTH, 5, shift-amount width, taken from b[SHAMT_WIDTH-1:0]
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- flush  in  1  synchronous abort of in-flight operation
- in_valid  in  1  operands and op are valid
- in_ready  out  1  unit can accept; high only in IDLE
- operation  in  4  ALU operation code
- a  in  DATA_WIDTH  SrcA
- b  in  DATA_WIDTH  SrcB
- out_valid  out  1  result valid; high only in DONE
- out_ready  in  1  consumer accepts result
- result  out  DATA_WIDTH  registered result
- branch_taken  out  1  registered branch/jump condition

## Operation
- Codes: AND 0000, OR 0001, ADD 0010, JAL 0011, SLL 0100, SRL 0101, XOR 0110, SRA 0111, BEQ 1000, BNE 1001, BLT 1010, BGE 1011, SLT 1100, SUB 1111. Codes 1101 and 1110 are undefined: result 0, branch_taken 0, latency 1.
- ADD/SUB wrap modulo 2^DATA_WIDTH. SLT signed: result 1 or 0. JAL: result = a + 4, branch_taken 1.
- BEQ a==b, BNE a!=b, BLT signed a<b, BGE signed a>=b drive branch_taken; result 0. Non-branch ops: branch_taken 0.
- Shifts: shamt = b[4:0]; upper bits ignored. SLL fills 0, SRL fills 0, SRA fills a[31] on every step.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid & !flush: latch op. Shift op with shamt≠0 → SHIFT (acc=a, cnt=shamt). Otherwise compute the result, register it → DONE.
- SHIFT: each edge shifts acc by 1 and decrements cnt. The edge where cnt==1 loads result=shifted acc → DONE.
- DONE: out_valid=1. result and branch_taken are held stable until out_ready. On out_ready → IDLE.
- flush in any state → IDLE next edge: out_valid low, no result. flush wins over a simultaneous in_valid or out_ready.
- in_valid outside IDLE is ignored. No accept in the same cycle as a DONE handshake.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, result 0, branch_taken 0, acc/cnt 0.
- Latency (accept cycle to first out_valid cycle): 1 for non-shift ops and for shamt 0; 1+N for a shift by N (1..31). Maximum is 32.
- Maximum throughput: one op per 2 cycles (accept, then DONE handshake).
- Reset asserted mid-SHIFT or in DONE: outputs immediately take reset values. The op is lost.
- in_ready and out_valid are decoded from the state register only. No combinational path from any input.

## Structure
- Package alu_pkg holds: typedef enum logic [3:0] alu_op_e with the codes above, the state enum, DATA_WIDTH/SHAMT_WIDTH constants.
- The ALU control decoder imports the same alu_op_e.
- Sub-module alu_shift_unit holds acc, cnt, direction and fill bit. It provides load/step/done signals and is instantiated once.

## Test plan
- Reset pulse mid-run → in_ready 1, out_valid 0, result 0, branch_taken 0 asynchronously.
- ADD a=5,b=7 → result 12 one cycle after accept. SUB a=3,b=5 → 0xFFFFFFFE. JAL a=0x100 → 0x104 with branch_taken 1.
- SRA a=0x80000000,b=4 → 0xF8000000 with latency 5. SRL same operands → 0x08000000. SLL b=0x20 (shamt 0) → result a, latency 1.
- BEQ 7,7 → branch_taken 1. BLT a=0xFFFFFFFF,b=1 → 1. BGE same → 0. BNE 3,3 → 0. SLT -2,1 → result 1.
- Backpressure: hold out_ready low 3 cycles in DONE while toggling in_valid → result stable, in_ready 0, no accept. Then a handshake returns to IDLE.
- SLL b=31 with flush at 10th SHIFT cycle → IDLE next edge, out_valid never asserted. The next ADD is accepted and completes normally.
